// File: rtl/heat_pkg.sv
// Shared encodings and default timing for the two-mode heating sequencer.
package heat_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEAT    = 2'b01,
    CHANGE  = 2'b10,
    LOCKOUT = 2'b11
  } heat_state_e;

  localparam logic MODE_A = 1'b0;
  localparam logic MODE_B = 1'b1;

  localparam int HYST_DEF    = 2;
  localparam int MIN_ON_DEF  = 60;
  localparam int MIN_OFF_DEF = 30;
  localparam int DEAD_DEF    = 10;

  function automatic logic [1:0] mode_onehot(input logic mode);
    return (mode == MODE_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/heat_tick_timer.sv
// Tick-driven up-counter with synchronous clear, saturating at a caller-chosen limit.
module heat_tick_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          clr,
  input  logic [CW-1:0] limit,
  output logic          done,
  output logic          hit
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (tick && !done)
      count <= count + CW'(1);
  end

  assign done = (count == limit);

  // hit flags the tick that completes the count, so the caller can act on that same edge
  assign hit = tick && !done && (({1'b0, count} + (CW+1)'(1)) == {1'b0, limit});

endmodule

// File: rtl/heat_mode_scheduler.sv
// Heating sequencer: hysteresis, minimum on/off dwell and changeover dead-time
// between the two heater modes; heaters are never both energised.
//
//   state   | meaning
//   IDLE    | heaters off, waiting for enable && demand_on
//   HEAT    | one heater on (onehot(mode_select)), MIN_ON dwell running
//   CHANGE  | heaters off for DEAD ticks before switching mode
//   LOCKOUT | heaters off for MIN_OFF ticks, inputs ignored
module heat_mode_scheduler
  import heat_pkg::*;
#(
  parameter int TW      = 8,
  parameter int HYST    = HYST_DEF,
  parameter int MIN_ON  = MIN_ON_DEF,
  parameter int MIN_OFF = MIN_OFF_DEF,
  parameter int DEAD    = DEAD_DEF,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          enable,
  input  logic [TW-1:0] temp_cur,
  input  logic [TW-1:0] temp_set,
  input  logic          mode_req,
  output logic          mode_select,
  output logic [1:0]    heat_on,
  output logic [1:0]    state
);

  heat_state_e   state_r, state_nx;
  logic          mode_r, mode_nx;
  logic [1:0]    heat_r, heat_nx;
  logic          tmr_clr, tmr_done, tmr_hit, reach;
  logic [CW-1:0] tmr_limit;
  logic [TW:0]   cur_ext, set_ext, hyst_ext;
  logic          demand_on, demand_off;

  // one extra bit so the hysteresis offset can never wrap
  assign cur_ext    = {1'b0, temp_cur};
  assign set_ext    = {1'b0, temp_set};
  assign hyst_ext   = (TW+1)'(HYST);
  assign demand_on  = (cur_ext + hyst_ext) < set_ext;
  assign demand_off = cur_ext >= (set_ext + hyst_ext);

  heat_tick_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .done  (tmr_done),
    .hit   (tmr_hit)
  );

  assign reach = tmr_done || tmr_hit;

  always_comb begin
    state_nx  = state_r;
    tmr_limit = CW'(MIN_ON);
    case (state_r)
      IDLE: begin
        if (enable && demand_on) state_nx = HEAT;
      end
      HEAT: begin
        tmr_limit = CW'(MIN_ON);
        if (!enable)                           state_nx = LOCKOUT;
        else if (demand_off && reach)          state_nx = LOCKOUT;
        else if ((mode_req != mode_r) && reach) state_nx = CHANGE;
      end
      CHANGE: begin
        tmr_limit = CW'(DEAD);
        if (!enable || demand_off) state_nx = LOCKOUT;
        else if (reach)            state_nx = HEAT;
      end
      LOCKOUT: begin
        tmr_limit = CW'(MIN_OFF);
        if (reach) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // every state starts its dwell from zero
    tmr_clr = (state_nx != state_r) || (state_r == IDLE);
    mode_nx = ((state_nx == HEAT) && (state_r != HEAT)) ? mode_req : mode_r;
    heat_nx = (state_nx == HEAT) ? mode_onehot(mode_nx) : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      mode_r  <= MODE_A;
      heat_r  <= 2'b00;
    end else begin
      state_r <= state_nx;
      mode_r  <= mode_nx;
      heat_r  <= heat_nx;
    end
  end

  assign state       = state_r;
  assign mode_select = mode_r;
  assign heat_on     = heat_r;

endmodule

// File: tb/tb_heat_mode_scheduler.sv
// Directed bench for heat_mode_scheduler with shortened dwell times.
module tb_heat_mode_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       enable;
  logic [7:0] temp_cur;
  logic [7:0] temp_set;
  logic       mode_req;
  logic       mode_select;
  logic [1:0] heat_on;
  logic [1:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [7:0] S_IDLE = 8'd0, S_HEAT = 8'd1, S_CHANGE = 8'd2, S_LOCK = 8'd3;

  always #5 clk = ~clk;

  heat_mode_scheduler #(
    .TW(8), .HYST(2), .MIN_ON(4), .MIN_OFF(3), .DEAD(2), .CW(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .enable      (enable),
    .temp_cur    (temp_cur),
    .temp_set    (temp_set),
    .mode_req    (mode_req),
    .mode_select (mode_select),
    .heat_on     (heat_on),
    .state       (state)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one clock cycle; inputs change just after negedge, results sampled at the next negedge
  task automatic cyc(input logic t);
    tick = t;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic check_out(input string tag, input logic [7:0] st, input logic [7:0] ho,
                           input logic [7:0] ms);
    check({tag, "_state"}, 8'(state), st);
    check({tag, "_heat"},  8'(heat_on), ho);
    check({tag, "_mode"},  8'(mode_select), ms);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("inv_not_both", 8'(heat_on == 2'b11), 8'd0);
      check("inv_heat_only_in_heat", 8'((heat_on != 2'b00) && (state != 2'b01)), 8'd0);
    end
  end

  initial begin
    rst = 1'b1; tick = 1'b0; enable = 1'b0;
    temp_cur = 8'd40; temp_set = 8'd40; mode_req = 1'b0;
    @(negedge clk); @(negedge clk);
    check_out("reset", S_IDLE, 8'd0, 8'd0);
    rst = 1'b0;

    // hysteresis band from IDLE
    enable = 1'b1; temp_cur = 8'd38;
    cyc(0); cyc(0);
    check("band38_idle", 8'(state), S_IDLE);
    temp_cur = 8'd39;
    cyc(0);
    check("band39_idle", 8'(state), S_IDLE);

    // heat-up then satisfied
    temp_cur = 8'd37;
    cyc(0);
    check_out("heatup", S_HEAT, 8'h01, 8'd0);
    temp_cur = 8'd42;
    ticks(2); cyc(0); ticks(1);
    check_out("heatup_3t", S_HEAT, 8'h01, 8'd0);
    ticks(1);
    check_out("heatup_lock", S_LOCK, 8'h00, 8'd0);
    ticks(2);
    check("lock_2t", 8'(state), S_LOCK);
    ticks(1);
    check_out("lock_done", S_IDLE, 8'h00, 8'd0);

    // hysteresis band inside HEAT after MIN_ON
    temp_cur = 8'd37;
    cyc(0);
    temp_cur = 8'd41;
    ticks(5);
    check_out("band41_heat", S_HEAT, 8'h01, 8'd0);
    temp_cur = 8'd42;
    cyc(0);
    check("band42_lock", 8'(state), S_LOCK);
    ticks(3);
    check("band_idle", 8'(state), S_IDLE);

    // minimum on-time holds a satisfied thermostat
    temp_cur = 8'd37;
    cyc(0);
    ticks(1);
    temp_cur = 8'd50;
    ticks(2);
    check_out("minon_3t", S_HEAT, 8'h01, 8'd0);
    ticks(1);
    check_out("minon_4t", S_LOCK, 8'h00, 8'd0);
    ticks(3);
    check("minon_idle", 8'(state), S_IDLE);

    // changeover A -> B
    temp_cur = 8'd37;
    cyc(0);
    check_out("chg_enter", S_HEAT, 8'h01, 8'd0);
    mode_req = 1'b1;
    ticks(3);
    check_out("chg_hold", S_HEAT, 8'h01, 8'd0);
    ticks(1);
    check_out("chg_dead", S_CHANGE, 8'h00, 8'd0);
    cyc(0); ticks(1);
    check_out("chg_dead1", S_CHANGE, 8'h00, 8'd0);
    ticks(1);
    check_out("chg_to_b", S_HEAT, 8'h02, 8'd1);

    // changeover request reverts during dead-time
    mode_req = 1'b0;
    ticks(4);
    check_out("rev_dead", S_CHANGE, 8'h00, 8'd1);
    ticks(1);
    mode_req = 1'b1;
    ticks(1);
    check_out("rev_back", S_HEAT, 8'h02, 8'd1);

    // enable drop overrides MIN_ON; lockout ignores inputs
    ticks(1);
    enable = 1'b0;
    cyc(0);
    check_out("en_drop", S_LOCK, 8'h00, 8'd1);
    enable = 1'b1;
    ticks(2);
    check("en_lock_hold", 8'(state), S_LOCK);
    ticks(1);
    check("en_lock_idle", 8'(state), S_IDLE);
    cyc(0);
    check_out("en_reheat", S_HEAT, 8'h02, 8'd1);

    // demand_off beats a simultaneous mode change
    ticks(3);
    temp_cur = 8'd50; mode_req = 1'b0;
    ticks(1);
    check_out("prio_lock", S_LOCK, 8'h00, 8'd1);
    ticks(3);
    check("prio_idle", 8'(state), S_IDLE);

    // asynchronous reset mid-HEAT
    temp_cur = 8'd37; mode_req = 1'b1;
    cyc(0);
    check_out("arst_pre", S_HEAT, 8'h02, 8'd1);
    ticks(1);
    #2 rst = 1'b1;
    #1;
    check_out("arst_now", S_IDLE, 8'h00, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0);
    check_out("arst_reheat", S_HEAT, 8'h02, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
